// File: rtl/mips_register_file_if.sv
// Register-file port bundle between the monocycle datapath and the register file.
// master: datapath/control side (drives indices, write enable and write data).
// slave : register file (returns the three combinational read ports).
//   RegWrite   write enable
//   ReadReg1/2 rs/rt read indices      -> ReadData1/2
//   WriteReg   destination index       WriteData  value to write
//   DbgAddr    debug read index        -> DbgData
interface mips_register_file_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
);
    logic                  RegWrite;
    logic [ADDR_WIDTH-1:0] ReadReg1;
    logic [ADDR_WIDTH-1:0] ReadReg2;
    logic [ADDR_WIDTH-1:0] WriteReg;
    logic [DATA_WIDTH-1:0] WriteData;
    logic [DATA_WIDTH-1:0] ReadData1;
    logic [DATA_WIDTH-1:0] ReadData2;
    logic [ADDR_WIDTH-1:0] DbgAddr;
    logic [DATA_WIDTH-1:0] DbgData;

    modport master (
        output RegWrite, ReadReg1, ReadReg2, WriteReg, WriteData, DbgAddr,
        input  ReadData1, ReadData2, DbgData
    );

    modport slave (
        input  RegWrite, ReadReg1, ReadReg2, WriteReg, WriteData, DbgAddr,
        output ReadData1, ReadData2, DbgData
    );
endinterface

// File: rtl/mips_register_file.sv
// 32 x 32-bit MIPS general-purpose register file.
// Ports:
//   clk    system clock, all updates on the rising edge
//   rst_n  synchronous active-low reset ($gp/$sp get their ABI start values)
//   bus    mips_register_file_if.slave: two combinational operand read ports,
//          one debug read port, one write port
// Reads have no write-to-read bypass: WriteData is derived combinationally from
// ReadData through the ALU, so a bypass would close a combinational loop.
module mips_register_file #(
    parameter int unsigned          DATA_WIDTH = 32,
    parameter int unsigned          ADDR_WIDTH = 5,
    parameter logic [DATA_WIDTH-1:0] GP_INIT   = 32'h1000_8000,
    parameter logic [DATA_WIDTH-1:0] SP_INIT   = 32'h7FFF_EFFC
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mips_register_file_if.slave    bus
);
    localparam int unsigned          NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] GP_IDX   = ADDR_WIDTH'(28);
    localparam logic [ADDR_WIDTH-1:0] SP_IDX   = ADDR_WIDTH'(29);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // Storage update: reset wins over any write; writes to r0 are dropped so
    // r0 storage stays zero forever.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
            regs[GP_IDX] <= GP_INIT;
            regs[SP_IDX] <= SP_INIT;
        end else if (bus.RegWrite && (bus.WriteReg != ZERO_IDX)) begin
            regs[bus.WriteReg] <= bus.WriteData;
        end
    end

    // Zero-latency read ports; index 0 is forced to zero independently of storage.
    always_comb begin
        bus.ReadData1 = '0;
        bus.ReadData2 = '0;
        bus.DbgData   = '0;
        if (bus.ReadReg1 != ZERO_IDX) begin
            bus.ReadData1 = regs[bus.ReadReg1];
        end
        if (bus.ReadReg2 != ZERO_IDX) begin
            bus.ReadData2 = regs[bus.ReadReg2];
        end
        if (bus.DbgAddr != ZERO_IDX) begin
            bus.DbgData = regs[bus.DbgAddr];
        end
    end
endmodule
